spi_cmd_sequencer: RTL and testbench
====================================

Name: spi_cmd_sequencer

Overview:
Parametrised successor to the single-command SPI bridge. It accepts register-read commands into a queue and turns each one into a single chip-select burst on the team's single-CS byte SPI master: an address byte, then RESP_BYTES dummy bytes. It captures the returned bytes and streams them out with valid/ready backpressure. It sits between the command/control logic and SPI_Master_With_Single_CS, whose MAX_BYTES_PER_CS must equal RESP_BYTES+1.

Parameters:
CMD_WIDTH, 3, command index width
RESP_BYTES, 2, response bytes per command (1..15)
FIFO_DEPTH, 4, command queue depth (power of 2, >=2)
ADDR_BASE, 8'h28, register address of command 0
READ_MASK, 8'h80, OR'd into address byte to mark a read
TIMEOUT_CLKS, 1024, max clocks waiting for one spi_rx_dv

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd  in  CMD_WIDTH  command index
cmd_ready  out  1  queue not full
out_byte  out  8  response byte
out_valid  out  1  out_byte valid
out_last  out  1  final byte of the response
out_cmd  out  CMD_WIDTH  command that produced out_byte
out_ready  in  1  sink accepts byte
spi_tx_byte  out  8  to master i_TX_Byte
spi_tx_dv  out  1  to master i_TX_DV (1-clock pulse)
spi_tx_count  out  $clog2(RESP_BYTES+2)  to master i_TX_Count, constant RESP_BYTES+1
spi_tx_ready  in  1  from master o_TX_Ready
spi_rx_byte  in  8  from master o_RX_Byte
spi_rx_dv  in  1  from master o_RX_DV
busy  out  1  state != IDLE or queue non-empty
fifo_level  out  $clog2(FIFO_DEPTH+1)  queued commands
err_timeout  out  1  sticky timeout flag
err_clear  in  1  clears err_timeout

Behaviour:
- Reset (async on rst high): state IDLE, queue empty, all outputs 0 except cmd_ready=1 and spi_tx_count=RESP_BYTES+1; response buffer cleared.
- Queue: push on cmd_valid&&cmd_ready; cmd_ready = level<FIFO_DEPTH. Push and pop in the same cycle leave the level unchanged. Pop occurs only on the IDLE->ISSUE transition.
- Address byte = (ADDR_BASE + cmd*RESP_BYTES) | READ_MASK, 8-bit wrap-around (carry discarded).
- Byte index k is 0..RESP_BYTES. k=0 is the address; k>=1 sends 8'h00.
- States:
  - IDLE: if the queue is non-empty, pop, latch cmd and address, set k=0, go to ISSUE.
  - ISSUE: when spi_tx_ready=1, drive spi_tx_dv=1 for exactly one clock with the byte for k, load the timeout counter, go to WAIT_RX.
  - WAIT_RX: on spi_rx_dv, discard the byte if k=0, else store it at buf[k-1]. If k=RESP_BYTES go to OUTPUT, else k++ and go to ISSUE. The timeout counter decrements each cycle; at 0, set err_timeout, discard the response, go to DRAIN.
  - DRAIN: wait for spi_tx_ready=1, then go to IDLE. No output is produced for the failed command.
  - OUTPUT: present buf[j] with out_valid=1, out_cmd=latched cmd, out_last=(j=RESP_BYTES-1). Advance j on out_valid&&out_ready. After the last byte is accepted, go to IDLE.
- out_byte, out_cmd and out_last are stable while out_valid=1 and out_ready=0.
- spi_tx_dv is never asserted outside ISSUE and never on two consecutive clocks.
- Minimum latency: cmd push to first out_valid = 2 + sum over bytes of (tx_ready wait + SPI byte time).
- err_clear has priority over a simultaneous timeout set in the same cycle? No: a set wins over a simultaneous err_clear.
- Commands pushed while a transaction is in flight are queued. Responses leave in command order.

Test Plan:
- Reset, push cmd=0, SPI model returns 8'hA5, 8'h11, 8'h22 -> spi_tx_byte sequence 8'hA8, 8'h00, 8'h00; out bytes 11 then 22; out_last on 22; out_cmd=0.
- Push cmd=7 with ADDR_BASE=8'hF8, RESP_BYTES=2 -> address = (8'hF8+14) mod 256 | 8'h80 = 8'h86.
- Push 5 commands back-to-back with FIFO_DEPTH=4 and idle SPI -> cmd_ready low at level 4 while the first is in flight. All 5 responses are returned in order with matching out_cmd.
- Hold out_ready=0 for 20 clocks during OUTPUT -> out_byte stays stable and no spi_tx_dv occurs. Releasing out_ready drains the bytes, then the next command starts.
- Suppress spi_rx_dv with TIMEOUT_CLKS=16 -> err_timeout=1 after 16 clocks and no out_valid. err_clear -> err_timeout=0; the next command completes normally.
- Assert rst in the middle of WAIT_RX -> all outputs reach their reset values asynchronously, the queue is empty, and no stale out_valid appears after reset is released.

Source files
------------

// File: rtl/spi_cmd_sequencer_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : spi_cmd_sequencer_if
// Brief  : Command, response stream and SPI-master signals of the sequencer.
// Rev    : 1.0
//------------------------------------------------------------------------------
interface spi_cmd_sequencer_if #(
    parameter int CMD_WIDTH  = 3,
    parameter int RESP_BYTES = 2,
    parameter int FIFO_DEPTH = 4
);
    logic                                  cmd_valid;
    logic [CMD_WIDTH-1:0]                  cmd;
    logic                                  cmd_ready;
    logic [7:0]                            out_byte;
    logic                                  out_valid;
    logic                                  out_last;
    logic [CMD_WIDTH-1:0]                  out_cmd;
    logic                                  out_ready;
    logic [7:0]                            spi_tx_byte;
    logic                                  spi_tx_dv;
    logic [$clog2(RESP_BYTES+2)-1:0]       spi_tx_count;
    logic                                  spi_tx_ready;
    logic [7:0]                            spi_rx_byte;
    logic                                  spi_rx_dv;
    logic                                  busy;
    logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_level;
    logic                                  err_timeout;
    logic                                  err_clear;

    modport master (
        input  cmd_valid, cmd, out_ready, spi_tx_ready, spi_rx_byte, spi_rx_dv, err_clear,
        output cmd_ready, out_byte, out_valid, out_last, out_cmd,
               spi_tx_byte, spi_tx_dv, spi_tx_count, busy, fifo_level, err_timeout
    );

    modport slave (
        output cmd_valid, cmd, out_ready, spi_tx_ready, spi_rx_byte, spi_rx_dv, err_clear,
        input  cmd_ready, out_byte, out_valid, out_last, out_cmd,
               spi_tx_byte, spi_tx_dv, spi_tx_count, busy, fifo_level, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/spi_cmd_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : spi_cmd_sequencer
// Brief  : Queues register-read commands, runs one CS burst per command on the
//          single-CS SPI master and streams the response bytes out.
// Rev    : 1.0
//------------------------------------------------------------------------------
module spi_cmd_sequencer #(
    parameter int         CMD_WIDTH    = 3,
    parameter int         RESP_BYTES   = 2,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] ADDR_BASE    = 8'h28,
    parameter logic [7:0] READ_MASK    = 8'h80,
    parameter int         TIMEOUT_CLKS = 1024
) (
    input  logic                clk,
    input  logic                rst,
    spi_cmd_sequencer_if.master bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_IDX_W = $clog2(RESP_BYTES + 1);
    localparam int c_CNT_W = $clog2(RESP_BYTES + 2);
    localparam int c_TMR_W = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [c_LVL_W-1:0] c_DEPTH    = c_LVL_W'(FIFO_DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST_K   = c_IDX_W'(RESP_BYTES);
    localparam logic [c_IDX_W-1:0] c_LAST_J   = c_IDX_W'(RESP_BYTES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LOAD = c_TMR_W'(TIMEOUT_CLKS - 1);
    localparam logic [c_CNT_W-1:0] c_TX_COUNT = c_CNT_W'(RESP_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_RX = 3'd2,
        S_DRAIN   = 3'd3,
        S_OUTPUT  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [CMD_WIDTH-1:0] r_fifo_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic [CMD_WIDTH-1:0] r_cmd;
    logic [7:0]           r_addr;
    logic [c_IDX_W-1:0]   r_k;
    logic [c_IDX_W-1:0]   r_j;
    logic [7:0]           r_buf [RESP_BYTES];
    logic [c_TMR_W-1:0]   r_timer;
    logic                 r_err;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_tx_fire;
    logic                 w_rx_take;
    logic                 w_timeout;
    logic                 w_out_fire;
    logic                 w_out_valid;
    logic [CMD_WIDTH-1:0] w_head;
    logic [7:0]           w_addr;
    logic [7:0]           w_out_byte;

    assign w_push      = bus.cmd_valid && (r_level < c_DEPTH);
    assign w_head      = r_fifo_mem[r_rd_ptr];
    // 8-bit arithmetic: the carry out of the address sum is intentionally lost
    assign w_addr      = (ADDR_BASE + 8'(w_head) * 8'(RESP_BYTES)) | READ_MASK;
    assign w_out_valid = (r_state == S_OUTPUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_tx_fire    = 1'b0;
        w_rx_take    = 1'b0;
        w_timeout    = 1'b0;
        w_out_fire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.spi_tx_ready) begin
                    w_tx_fire    = 1'b1;
                    w_state_next = S_WAIT_RX;
                end
            end
            S_WAIT_RX: begin
                // a byte arriving on the last allowed clock still counts
                if (bus.spi_rx_dv) begin
                    w_rx_take    = 1'b1;
                    w_state_next = (r_k == c_LAST_K) ? S_OUTPUT : S_ISSUE;
                end else if (r_timer == '0) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.spi_tx_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            S_OUTPUT: begin
                if (bus.out_ready) begin
                    w_out_fire = 1'b1;
                    if (r_j == c_LAST_J) begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= bus.cmd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd   <= '0;
            r_addr  <= 8'h00;
            r_k     <= '0;
            r_j     <= '0;
            r_timer <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < RESP_BYTES; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else begin
            if (w_pop) begin
                r_cmd  <= w_head;
                r_addr <= w_addr;
                r_k    <= '0;
                r_j    <= '0;
            end
            if (w_tx_fire) begin
                r_timer <= c_TMR_LOAD;
            end else if ((r_state == S_WAIT_RX) && (r_timer != '0)) begin
                r_timer <= r_timer - c_TMR_W'(1);
            end
            if (w_rx_take) begin
                for (int i = 0; i < RESP_BYTES; i++) begin
                    if (r_k == c_IDX_W'(i + 1)) begin
                        r_buf[i] <= bus.spi_rx_byte;
                    end
                end
                if (r_k != c_LAST_K) begin
                    r_k <= r_k + c_IDX_W'(1);
                end
            end
            if (w_out_fire) begin
                r_j <= r_j + c_IDX_W'(1);
            end
            // a timeout in the same clock as err_clear leaves the flag set
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (bus.err_clear) begin
                r_err <= 1'b0;
            end
        end
    end

    always_comb begin
        w_out_byte = 8'h00;
        for (int i = 0; i < RESP_BYTES; i++) begin
            if (r_j == c_IDX_W'(i)) begin
                w_out_byte = r_buf[i];
            end
        end
    end

    assign bus.cmd_ready    = (r_level < c_DEPTH);
    assign bus.out_valid    = w_out_valid;
    assign bus.out_byte     = w_out_valid ? w_out_byte : 8'h00;
    assign bus.out_last     = w_out_valid && (r_j == c_LAST_J);
    assign bus.out_cmd      = w_out_valid ? r_cmd : '0;
    assign bus.spi_tx_byte  = (r_k == '0) ? r_addr : 8'h00;
    assign bus.spi_tx_dv    = w_tx_fire;
    assign bus.spi_tx_count = c_TX_COUNT;
    assign bus.busy         = (r_state != S_IDLE) || (r_level != '0);
    assign bus.fifo_level   = r_level;
    assign bus.err_timeout  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_spi_cmd_sequencer
// Brief  : Randomized scoreboard bench with a behavioural SPI slave model.
// Rev    : 1.0
//------------------------------------------------------------------------------
module tb_spi_cmd_sequencer;
    localparam int         CW    = 3;
    localparam int         RESP  = 2;
    localparam int         DEPTH = 4;
    localparam int         TMO   = 16;
    localparam logic [7:0] ABASE = 8'hF8;
    localparam logic [7:0] RMASK = 8'h80;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        bit         drop;
    } tx_exp_t;

    typedef struct {
        logic [7:0]    b;
        bit            last;
        logic [CW-1:0] c;
    } out_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_cmd_sequencer_if #(.CMD_WIDTH(CW), .RESP_BYTES(RESP), .FIFO_DEPTH(DEPTH)) bus ();

    spi_cmd_sequencer #(
        .CMD_WIDTH   (CW),
        .RESP_BYTES  (RESP),
        .FIFO_DEPTH  (DEPTH),
        .ADDR_BASE   (ABASE),
        .READ_MASK   (RMASK),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         checks = 0;
    int         errors = 0;
    tx_exp_t    exp_tx [$];
    out_exp_t   exp_out[$];
    logic [7:0] resp_data [RESP];
    logic [7:0] addr_junk;
    bit         stall = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_to(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired, got no event, expected one", name);
    endfunction

    // Reference: one address byte then RESP zero bytes; response returned in order
    function automatic void expect_cmd(input logic [CW-1:0] c, input bit drop);
        tx_exp_t  e;
        out_exp_t o;
        int       a;
        a      = ((int'(ABASE) + int'(c) * RESP) % 256) | int'(RMASK);
        e.tx   = 8'(a);
        e.rx   = addr_junk;
        e.drop = drop;
        exp_tx.push_back(e);
        if (!drop) begin
            for (int k = 0; k < RESP; k++) begin
                e.tx   = 8'h00;
                e.rx   = resp_data[k];
                e.drop = 1'b0;
                exp_tx.push_back(e);
                o.b    = resp_data[k];
                o.last = (k == RESP - 1);
                o.c    = c;
                exp_out.push_back(o);
            end
        end
    endfunction

    task automatic push_cmd(input logic [CW-1:0] c, input bit drop, input bit rnd);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            fail_to("push_wait");
        end else begin
            if (rnd) begin
                addr_junk = 8'($urandom);
                for (int k = 0; k < RESP; k++) resp_data[k] = 8'($urandom);
            end
            expect_cmd(c, drop);
            bus.cmd_valid = 1'b1;
            bus.cmd       = c;
            @(negedge clk);
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy !== 1'b0 || exp_out.size() != 0 || exp_tx.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_to("wait_idle");
    endtask

    function automatic void check_reset_values(input string tag);
        chk({tag, "_cmd_ready"},    32'(bus.cmd_ready),    1);
        chk({tag, "_out_valid"},    32'(bus.out_valid),    0);
        chk({tag, "_out_last"},     32'(bus.out_last),     0);
        chk({tag, "_out_byte"},     32'(bus.out_byte),     0);
        chk({tag, "_out_cmd"},      32'(bus.out_cmd),      0);
        chk({tag, "_spi_tx_dv"},    32'(bus.spi_tx_dv),    0);
        chk({tag, "_spi_tx_byte"},  32'(bus.spi_tx_byte),  0);
        chk({tag, "_spi_tx_count"}, 32'(bus.spi_tx_count), RESP + 1);
        chk({tag, "_busy"},         32'(bus.busy),         0);
        chk({tag, "_fifo_level"},   32'(bus.fifo_level),   0);
        chk({tag, "_err_timeout"},  32'(bus.err_timeout),  0);
    endfunction

    // Slave model: checks each transmitted byte, answers after a random delay
    initial begin : spi_model
        tx_exp_t e;
        bus.spi_tx_ready = 1'b1;
        bus.spi_rx_dv    = 1'b0;
        bus.spi_rx_byte  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && bus.spi_tx_dv === 1'b1) begin
                if (exp_tx.size() == 0) begin
                    chk("spi_tx_unexpected", 32'(bus.spi_tx_byte), 32'hFFFF_FFFF);
                    e.tx = 8'h00; e.rx = 8'h00; e.drop = 1'b0;
                end else begin
                    e = exp_tx.pop_front();
                    chk("spi_tx_byte", 32'(bus.spi_tx_byte), 32'(e.tx));
                end
                @(posedge clk);
                #1 bus.spi_tx_ready = 1'b0;
                repeat ($urandom_range(2, 5)) @(negedge clk);
                if (!e.drop) begin
                    bus.spi_rx_byte = e.rx;
                    bus.spi_rx_dv   = 1'b1;
                    @(negedge clk);
                    bus.spi_rx_dv   = 1'b0;
                end else begin
                    repeat (TMO + 6) @(negedge clk);
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                @(posedge clk);
                #1 bus.spi_tx_ready = 1'b1;
            end
        end
    end

    initial begin : sink
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2 bus.out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : monitor
        logic          prev_stall;
        logic          prev_dv;
        logic [7:0]    pb;
        logic          pl;
        logic [CW-1:0] pc;
        out_exp_t      o;
        prev_stall = 1'b0;
        prev_dv    = 1'b0;
        pb = 8'h00; pl = 1'b0; pc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                prev_dv    = 1'b0;
            end else begin
                if (bus.spi_tx_dv === 1'b1) begin
                    chk("tx_dv_back_to_back", 32'(prev_dv), 0);
                    chk("tx_dv_during_output", 32'(bus.out_valid), 0);
                end
                if (prev_stall) begin
                    chk("hold_valid", 32'(bus.out_valid), 1);
                    chk("hold_byte",  32'(bus.out_byte), 32'(pb));
                    chk("hold_last",  32'(bus.out_last), 32'(pl));
                    chk("hold_cmd",   32'(bus.out_cmd),  32'(pc));
                end
                if (bus.out_valid === 1'b1 && exp_out.size() == 0) begin
                    chk("unexpected_out_valid", 32'(bus.out_byte), 32'hFFFF_FFFF);
                end else if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                    o = exp_out.pop_front();
                    chk("out_byte", 32'(bus.out_byte), 32'(o.b));
                    chk("out_last", 32'(bus.out_last), 32'(o.last));
                    chk("out_cmd",  32'(bus.out_cmd),  32'(o.c));
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_dv    = bus.spi_tx_dv;
                pb = bus.out_byte;
                pl = bus.out_last;
                pc = bus.out_cmd;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd       = '0;
        bus.err_clear = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // directed: cmd 0, slave returns A5 / 11 / 22
        addr_junk    = 8'hA5;
        resp_data[0] = 8'h11;
        resp_data[1] = 8'h22;
        push_cmd(3'd0, 1'b0, 1'b0);
        wait_idle();

        // address wrap: (F8 + 7*2) mod 256 | 80 = 86
        push_cmd(3'd7, 1'b0, 1'b1);
        wait_idle();

        // five back-to-back pushes fill the queue behind the in-flight command
        for (int i = 0; i < 5; i++) push_cmd(CW'(i + 2), 1'b0, 1'b1);
        chk("full_fifo_level", 32'(bus.fifo_level), DEPTH);
        chk("full_cmd_ready",  32'(bus.cmd_ready),  0);
        wait_idle();

        // backpressure for 20 clocks with a command still queued
        push_cmd(3'd1, 1'b0, 1'b1);
        push_cmd(3'd4, 1'b0, 1'b1);
        stall = 1'b1;
        @(posedge clk);
        @(posedge clk);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_to("stall_out_valid");
        repeat (20) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.out_valid), 1);
            chk("stall_no_tx", 32'(bus.spi_tx_dv), 0);
            chk("stall_level", 32'(bus.fifo_level), 1);
            if (exp_out.size() != 0) chk("stall_byte", 32'(bus.out_byte), 32'(exp_out[0].b));
        end
        stall = 1'b0;
        wait_idle();

        // timeout with no rx_dv
        push_cmd(3'd5, 1'b1, 1'b1);
        n = 0;
        while (bus.spi_tx_dv !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_to("timeout_tx_dv");
        n = 0;
        while (bus.err_timeout !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", 32'(n), TMO + 1);
        wait_idle();
        chk("err_sticky", 32'(bus.err_timeout), 1);
        bus.err_clear = 1'b1;
        @(negedge clk);
        bus.err_clear = 1'b0;
        chk("err_cleared", 32'(bus.err_timeout), 0);
        push_cmd(3'd6, 1'b0, 1'b1);
        wait_idle();

        // set beats a simultaneous clear
        bus.err_clear = 1'b1;
        push_cmd(3'd2, 1'b1, 1'b1);
        n = 0;
        while (bus.spi_tx_dv !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_to("setwins_tx_dv");
        n = 0;
        while (bus.err_timeout !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("setwins_latency", 32'(n), TMO + 1);
        @(negedge clk);
        chk("setwins_then_clear", 32'(bus.err_timeout), 0);
        bus.err_clear = 1'b0;
        wait_idle();

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push_cmd(CW'($urandom_range(0, 7)), 1'b0, 1'b1);
        end
        wait_idle();

        // asynchronous reset while waiting for the first rx byte
        push_cmd(3'd3, 1'b0, 1'b1);
        push_cmd(3'd4, 1'b0, 1'b1);
        push_cmd(3'd5, 1'b0, 1'b1);
        n = 0;
        while (bus.spi_tx_ready !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_to("reset_wait_rx");
        #2 rst = 1'b1;
        #1 check_reset_values("async_reset");
        exp_tx.delete();
        exp_out.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_reset_valid", 32'(bus.out_valid), 0);
        chk("post_reset_busy",  32'(bus.busy), 0);
        push_cmd(3'd1, 1'b0, 1'b1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
